// File: rtl/scmips_pkg.sv
// ============================================================================
// Module   : scmips_pkg
// Brief    : Shared types and constants for the register-file port arbiter.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package scmips_pkg;

  localparam int RF_ADDR_W = 3;
  localparam int RF_DATA_W = 8;

  localparam logic RF_READ  = 1'b0;
  localparam logic RF_WRITE = 1'b1;

  typedef enum logic [0:0] {
    INIT = 1'b0,
    ARB  = 1'b1
  } rfa_state_t;

endpackage

`default_nettype wire

// File: rtl/regfile_port_arbiter_if.sv
// ============================================================================
// Module   : regfile_port_arbiter_if
// Brief    : Core, debug and register-file signal bundle for the arbiter.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

interface regfile_port_arbiter_if #(
  parameter int ADDR_W = scmips_pkg::RF_ADDR_W,
  parameter int DATA_W = scmips_pkg::RF_DATA_W
) ();

  logic              c_req;
  logic              c_we;
  logic [ADDR_W-1:0] c_raddr1;
  logic [ADDR_W-1:0] c_raddr2;
  logic [ADDR_W-1:0] c_waddr;
  logic [DATA_W-1:0] c_wdata;
  logic              c_gnt;
  logic [DATA_W-1:0] c_rdata1;
  logic [DATA_W-1:0] c_rdata2;
  logic              c_rvalid;

  logic              d_req;
  logic              d_we;
  logic [ADDR_W-1:0] d_addr;
  logic [DATA_W-1:0] d_wdata;
  logic              d_gnt;
  logic [DATA_W-1:0] d_rdata;
  logic              d_rvalid;

  logic [ADDR_W-1:0] rf_read_1;
  logic [ADDR_W-1:0] rf_read_2;
  logic [ADDR_W-1:0] rf_write;
  logic              rf_read_write;
  logic [DATA_W-1:0] rf_in_data;
  logic [DATA_W-1:0] rf_out_1;
  logic [DATA_W-1:0] rf_out_2;

  logic              init_done;

  modport slave (
    input  c_req, c_we, c_raddr1, c_raddr2, c_waddr, c_wdata,
    output c_gnt, c_rdata1, c_rdata2, c_rvalid,
    input  d_req, d_we, d_addr, d_wdata,
    output d_gnt, d_rdata, d_rvalid,
    output rf_read_1, rf_read_2, rf_write, rf_read_write, rf_in_data,
    input  rf_out_1, rf_out_2,
    output init_done
  );

  modport master (
    output c_req, c_we, c_raddr1, c_raddr2, c_waddr, c_wdata,
    input  c_gnt, c_rdata1, c_rdata2, c_rvalid,
    output d_req, d_we, d_addr, d_wdata,
    input  d_gnt, d_rdata, d_rvalid,
    input  rf_read_1, rf_read_2, rf_write, rf_read_write, rf_in_data,
    output rf_out_1, rf_out_2,
    input  init_done
  );

endinterface

`default_nettype wire

// File: rtl/regfile_port_arbiter_rr_arbiter2.sv
// ============================================================================
// Module   : rr_arbiter2
// Brief    : Two-way round-robin grant; last_q remembers the most recent winner.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module rr_arbiter2 (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       en_i,
  input  logic [1:0] req_i,
  output logic [1:0] gnt_o
);

  logic       last_q;
  logic       last_d;
  logic [1:0] gnt;

  // On a tie the side that did not win last time is served.
  always_comb begin
    gnt = 2'b00;
    if (en_i) begin
      case (req_i)
        2'b01:   gnt = 2'b01;
        2'b10:   gnt = 2'b10;
        2'b11:   gnt = last_q ? 2'b01 : 2'b10;
        default: gnt = 2'b00;
      endcase
    end
    last_d = last_q;
    if (gnt[0]) begin
      last_d = 1'b0;
    end else if (gnt[1]) begin
      last_d = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      last_q <= 1'b1;
    end else begin
      last_q <= last_d;
    end
  end

  assign gnt_o = gnt;

endmodule

`default_nettype wire

// File: rtl/regfile_port_arbiter.sv
// ============================================================================
// Module   : regfile_port_arbiter
// Brief    : Clears the register file after reset, then shares its single
//            port between core and debug requesters with registered read data.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module regfile_port_arbiter
  import scmips_pkg::*;
#(
  parameter int NUM_REGS = 8,
  parameter int ADDR_W   = RF_ADDR_W,
  parameter int DATA_W   = RF_DATA_W
) (
  input  logic                   clk,
  input  logic                   rst_n,
  regfile_port_arbiter_if.slave  bus
);

  localparam logic [ADDR_W:0] INIT_LAST = (ADDR_W+1)'(NUM_REGS - 1);

  rfa_state_t        state_q, state_d;
  logic [ADDR_W:0]   init_cnt_q, init_cnt_d;
  logic              init_done_q, init_done_d;
  logic [DATA_W-1:0] c_rdata1_q, c_rdata2_q, d_rdata_q;
  logic              c_rvalid_q, d_rvalid_q;

  logic              arb_en;
  logic              gnt_core;
  logic              gnt_dbg;
  logic              rf_rw;
  logic [ADDR_W-1:0] rf_r1, rf_r2, rf_w;
  logic [DATA_W-1:0] rf_wd;

  assign arb_en = rst_n && (state_q == ARB);

  rr_arbiter2 u_rr (
    .clk   (clk),
    .rst_n (rst_n),
    .en_i  (arb_en),
    .req_i ({bus.d_req, bus.c_req}),
    .gnt_o ({gnt_dbg, gnt_core})
  );

  always_comb begin
    state_d     = state_q;
    init_cnt_d  = init_cnt_q;
    init_done_d = init_done_q;
    rf_rw       = RF_READ;
    rf_r1       = '0;
    rf_r2       = '0;
    rf_w        = '0;
    rf_wd       = '0;
    case (state_q)
      INIT: begin
        rf_rw      = RF_WRITE;
        rf_w       = init_cnt_q[ADDR_W-1:0];
        init_cnt_d = init_cnt_q + 1'b1;
        if (init_cnt_q == INIT_LAST) begin
          state_d     = ARB;
          init_done_d = 1'b1;
        end
      end
      ARB: begin
        if (gnt_core) begin
          if (bus.c_we) begin
            rf_rw = RF_WRITE;
            rf_w  = bus.c_waddr;
            rf_wd = bus.c_wdata;
          end else begin
            rf_r1 = bus.c_raddr1;
            rf_r2 = bus.c_raddr2;
          end
        end else if (gnt_dbg) begin
          if (bus.d_we) begin
            rf_rw = RF_WRITE;
            rf_w  = bus.d_addr;
            rf_wd = bus.d_wdata;
          end else begin
            rf_r1 = bus.d_addr;
          end
        end
      end
      default: state_d = INIT;
    endcase
    // The clear sequence must not write while reset is still held.
    if (!rst_n) begin
      rf_rw = RF_READ;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= INIT;
      init_cnt_q  <= '0;
      init_done_q <= 1'b0;
      c_rdata1_q  <= '0;
      c_rdata2_q  <= '0;
      d_rdata_q   <= '0;
      c_rvalid_q  <= 1'b0;
      d_rvalid_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      init_cnt_q  <= init_cnt_d;
      init_done_q <= init_done_d;
      c_rvalid_q  <= gnt_core && !bus.c_we;
      d_rvalid_q  <= gnt_dbg && !bus.d_we;
      if (gnt_core && !bus.c_we) begin
        c_rdata1_q <= bus.rf_out_1;
        c_rdata2_q <= bus.rf_out_2;
      end
      if (gnt_dbg && !bus.d_we) begin
        d_rdata_q <= bus.rf_out_1;
      end
    end
  end

  assign bus.c_gnt         = gnt_core;
  assign bus.d_gnt         = gnt_dbg;
  assign bus.c_rdata1      = c_rdata1_q;
  assign bus.c_rdata2      = c_rdata2_q;
  assign bus.c_rvalid      = c_rvalid_q;
  assign bus.d_rdata       = d_rdata_q;
  assign bus.d_rvalid      = d_rvalid_q;
  assign bus.rf_read_1     = rf_r1;
  assign bus.rf_read_2     = rf_r2;
  assign bus.rf_write      = rf_w;
  assign bus.rf_read_write = rf_rw;
  assign bus.rf_in_data    = rf_wd;
  assign bus.init_done     = init_done_q;

endmodule

`default_nettype wire

// File: tb/tb_regfile_port_arbiter.sv
// ============================================================================
// Module   : tb_regfile_port_arbiter
// Brief    : Scoreboard bench: register-file model, request drivers, monitor.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_regfile_port_arbiter;

  localparam int NREG = 8;

  logic clk;
  logic rst_n;
  int   n_checks = 0;
  int   n_fail   = 0;

  regfile_port_arbiter_if bus ();

  regfile_port_arbiter #(.NUM_REGS(NREG), .ADDR_W(3), .DATA_W(8)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Register file: no reset, combinational read, write on rising edge.
  logic [7:0] rf_mem [NREG];
  assign bus.rf_out_1 = rf_mem[bus.rf_read_1];
  assign bus.rf_out_2 = rf_mem[bus.rf_read_2];
  always @(posedge clk) begin
    if (bus.rf_read_write) rf_mem[bus.rf_write] <= bus.rf_in_data;
  end

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Reference model state
  logic [7:0]  m_regs [NREG];
  int          m_cyc;
  logic        m_last;
  logic        c_pend, d_pend;
  logic [15:0] c_hold;
  logic [7:0]  d_hold;
  logic [15:0] c_q [$];
  logic [7:0]  d_q [$];
  logic        exp_c, exp_d;

  always @(negedge clk) begin
    if (!rst_n) begin
      chk("rst_gnt", {bus.c_gnt, bus.d_gnt}, 0);
      chk("rst_rf_rw", bus.rf_read_write, 0);
      chk("rst_rvalid", {bus.c_rvalid, bus.d_rvalid}, 0);
      chk("rst_rdata", {bus.c_rdata1, bus.c_rdata2, bus.d_rdata}, 0);
      chk("rst_init_done", bus.init_done, 0);
      m_cyc = 0; m_last = 1'b1; c_pend = 1'b0; d_pend = 1'b0;
      c_hold = '0; d_hold = '0;
      c_q.delete(); d_q.delete();
      for (int i = 0; i < NREG; i++) m_regs[i] = 8'h00;
    end else begin
      chk("c_rvalid", bus.c_rvalid, c_pend);
      if (bus.c_rvalid && c_q.size() > 0) c_hold = c_q.pop_front();
      chk("c_rdata", {bus.c_rdata1, bus.c_rdata2}, c_hold);
      chk("d_rvalid", bus.d_rvalid, d_pend);
      if (bus.d_rvalid && d_q.size() > 0) d_hold = d_q.pop_front();
      chk("d_rdata", bus.d_rdata, d_hold);
      c_pend = 1'b0; d_pend = 1'b0;
      if (m_cyc < NREG) begin
        chk("init_rf_rw", bus.rf_read_write, 1);
        chk("init_addr", bus.rf_write, m_cyc);
        chk("init_data", bus.rf_in_data, 0);
        chk("init_gnt", {bus.c_gnt, bus.d_gnt}, 0);
        chk("init_done_lo", bus.init_done, 0);
        m_cyc++;
      end else begin
        chk("init_done_hi", bus.init_done, 1);
        exp_c = bus.c_req && (!bus.d_req || m_last);
        exp_d = bus.d_req && !exp_c;
        chk("c_gnt", bus.c_gnt, exp_c);
        chk("d_gnt", bus.d_gnt, exp_d);
        if (exp_c) begin
          m_last = 1'b0;
          if (bus.c_we) begin
            chk("c_wr_rf", {bus.rf_read_write, bus.rf_write, bus.rf_in_data},
                {1'b1, bus.c_waddr, bus.c_wdata});
            m_regs[bus.c_waddr] = bus.c_wdata;
          end else begin
            chk("c_rd_rf", {bus.rf_read_write, bus.rf_read_1, bus.rf_read_2},
                {1'b0, bus.c_raddr1, bus.c_raddr2});
            c_q.push_back({m_regs[bus.c_raddr1], m_regs[bus.c_raddr2]});
            c_pend = 1'b1;
          end
        end else if (exp_d) begin
          m_last = 1'b1;
          if (bus.d_we) begin
            chk("d_wr_rf", {bus.rf_read_write, bus.rf_write, bus.rf_in_data},
                {1'b1, bus.d_addr, bus.d_wdata});
            m_regs[bus.d_addr] = bus.d_wdata;
          end else begin
            chk("d_rd_rf", {bus.rf_read_write, bus.rf_read_1, bus.rf_read_2},
                {1'b0, bus.d_addr, 3'd0});
            d_q.push_back(m_regs[bus.d_addr]);
            d_pend = 1'b1;
          end
        end else begin
          chk("idle_rf", {bus.rf_read_write, bus.rf_read_1, bus.rf_read_2,
                          bus.rf_write, bus.rf_in_data}, 0);
        end
      end
    end
  end

  task automatic core_op(input logic we, input logic [2:0] a1, input logic [2:0] a2,
                         input logic [2:0] wa, input logic [7:0] wd);
    int n = 0;
    bus.c_we = we; bus.c_raddr1 = a1; bus.c_raddr2 = a2;
    bus.c_waddr = wa; bus.c_wdata = wd; bus.c_req = 1'b1;
    do begin @(negedge clk); n++; end while (!bus.c_gnt && n < 200);
    if (!bus.c_gnt) begin
      n_checks++; n_fail++;
      $display("FAIL core_timeout: got no grant expected c_gnt within 200 cycles");
    end
    @(posedge clk); #1;
    bus.c_req = 1'b0;
  endtask

  task automatic dbg_op(input logic we, input logic [2:0] a, input logic [7:0] wd);
    int n = 0;
    bus.d_we = we; bus.d_addr = a; bus.d_wdata = wd; bus.d_req = 1'b1;
    do begin @(negedge clk); n++; end while (!bus.d_gnt && n < 200);
    if (!bus.d_gnt) begin
      n_checks++; n_fail++;
      $display("FAIL dbg_timeout: got no grant expected d_gnt within 200 cycles");
    end
    @(posedge clk); #1;
    bus.d_req = 1'b0;
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog: got no finish expected end of test");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0;
    bus.c_req = 0; bus.c_we = 0; bus.c_raddr1 = 0; bus.c_raddr2 = 0;
    bus.c_waddr = 0; bus.c_wdata = 0;
    bus.d_req = 0; bus.d_we = 0; bus.d_addr = 0; bus.d_wdata = 0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;

    // Read requested during INIT must wait, then return the cleared value.
    core_op(0, 3'd5, 3'd0, 3'd0, 8'h00);
    @(negedge clk); chk("dir_r5", bus.c_rdata1, 8'h00);

    core_op(1, 3'd0, 3'd0, 3'd3, 8'hA5);
    core_op(0, 3'd3, 3'd0, 3'd0, 8'h00);
    @(negedge clk); chk("dir_r3_r0", {bus.c_rdata1, bus.c_rdata2}, 16'hA500);
    @(posedge clk); #1;

    fork
      begin
        core_op(0, 3'd1, 3'd2, 3'd0, 8'h00);
        core_op(1, 3'd0, 3'd0, 3'd4, 8'h44);
        core_op(0, 3'd4, 3'd3, 3'd0, 8'h00);
      end
      begin
        dbg_op(0, 3'd3, 8'h00);
        dbg_op(1, 3'd6, 8'h66);
        dbg_op(0, 3'd6, 8'h00);
      end
    join

    core_op(1, 3'd0, 3'd0, 3'd2, 8'h11);
    dbg_op(0, 3'd2, 8'h00);
    @(negedge clk); chk("dir_d_r2", bus.d_rdata, 8'h11);
    @(posedge clk); #1;

    fork
      core_op(0, 3'd7, 3'd0, 3'd0, 8'h00);
      dbg_op(1, 3'd7, 8'h3C);
    join
    @(negedge clk); chk("dir_r7_old", bus.c_rdata1, 8'h00);
    @(posedge clk); #1;
    core_op(0, 3'd7, 3'd0, 3'd0, 8'h00);
    @(negedge clk); chk("dir_r7_new", bus.c_rdata1, 8'h3C);
    @(posedge clk); #1;

    // Reset lands inside a core read-grant cycle.
    fork
      core_op(0, 3'd3, 3'd7, 3'd0, 8'h00);
      begin
        int n = 0;
        do begin @(negedge clk); n++; end while (!bus.c_gnt && n < 50);
        #1 rst_n = 1'b0;
        #1 chk("midrst_out", {bus.c_rdata1, bus.c_rdata2, bus.d_rdata,
                              bus.c_rvalid, bus.init_done}, 0);
      end
    join
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    core_op(0, 3'd3, 3'd7, 3'd0, 8'h00);
    @(negedge clk); chk("dir_rst_r3", {bus.c_rdata1, bus.c_rdata2}, 16'h0000);
    @(posedge clk); #1;

    fork
      for (int i = 0; i < 150; i++) begin
        repeat ($urandom_range(0, 2)) begin @(posedge clk); #1; end
        core_op(1'($urandom_range(0, 1)), 3'($urandom), 3'($urandom),
                3'($urandom), 8'($urandom));
      end
      for (int j = 0; j < 150; j++) begin
        repeat ($urandom_range(0, 2)) begin @(posedge clk); #1; end
        dbg_op(1'($urandom_range(0, 1)), 3'($urandom), 8'($urandom));
      end
    join

    repeat (3) @(negedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/regfile_port_arbiter.md
# regfile_port_arbiter

Controller that sits between the 8×8 register file and its two users: the core datapath (two-read/one-write operand port) and the debug/loader port (single read or write). The register file has no reset and one shared read/write mode line, so only one operation can occur per cycle. After reset this block clears all registers through the write port. It then arbitrates each cycle between the two requesters with round-robin fairness, drives the register-file control lines, and returns registered read data.

## Interface
- `NUM_REGS`, 8: registers cleared by the init sequence.
- `ADDR_W`, 3: register address width.
- `DATA_W`, 8: register data width.
- `clk` in 1: single clock; register-file writes occur on its rising edge.
- `rst_n` in 1: asynchronous active-low reset.
- `c_req` in 1: core request; the core holds it and all `c_*` fields stable until `c_gnt`.
- `c_we` in 1: 1 selects a write, 0 selects a read.
- `c_raddr1`, `c_raddr2` in ADDR_W: core read addresses.
- `c_waddr` in ADDR_W: core write address.
- `c_wdata` in DATA_W: core write data.
- `c_gnt` out 1: core operation issued this cycle.
- `c_rdata1`, `c_rdata2` out DATA_W: registered core read data.
- `c_rvalid` out 1: core read data valid, one-cycle pulse.
- `d_req`, `d_we` in 1: debug request and write select; same hold rule as the core.
- `d_addr` in ADDR_W: debug address, used for both read and write.
- `d_wdata` in DATA_W: debug write data.
- `d_gnt` out 1: debug operation issued this cycle.
- `d_rdata` out DATA_W: registered debug read data.
- `d_rvalid` out 1: debug read data valid, one-cycle pulse.
- `rf_read_1`, `rf_read_2`, `rf_write` out ADDR_W: register-file address lines.
- `rf_read_write` out 1: register-file mode line; 0 = read, 1 = write.
- `rf_in_data` out DATA_W: register-file write data.
- `rf_out_1`, `rf_out_2` in DATA_W: combinational register-file read data.
- `init_done` out 1: high once the clear sequence has completed.

## Operation
- FSM states: INIT → ARB.
  - Reset puts the FSM in INIT with `init_cnt` = 0.
- INIT:
  - Each cycle drives `rf_read_write`=1, `rf_write`=`init_cnt`, `rf_in_data`=0, then increments `init_cnt`.
  - After the cycle with `init_cnt`=NUM_REGS-1, the FSM moves to ARB and sets `init_done`=1.
  - No grants are issued in INIT; requests are held off.
- ARB, per cycle:
  - Exactly one of the following: idle, core grant, or debug grant.
  - Only one requester active: that requester is granted.
  - Both active: the requester not granted most recently is granted. `rr_last` records the last grantee (0 = core, 1 = debug).
  - `rr_last` updates only on a grant.
- Core grant:
  - Write: `rf_read_write`=1, `rf_write`=`c_waddr`, `rf_in_data`=`c_wdata`.
  - Read: `rf_read_write`=0, `rf_read_1`=`c_raddr1`, `rf_read_2`=`c_raddr2`; `rf_out_1`/`rf_out_2` are captured into `c_rdata1`/`c_rdata2` at the clock edge.
- Debug grant:
  - Write: as for the core, using `d_addr`/`d_wdata`.
  - Read: `rf_read_1`=`d_addr`, `rf_read_2`=0; `rf_out_1` is captured into `d_rdata`.
- Idle cycle: `rf_read_write`=0, all `rf_*` addresses 0, `rf_in_data`=0.
- Grants are combinational from state, requests and `rr_last`.
  - The requester drops or changes its request in the cycle after `gnt`.
  - A request still asserted after `gnt` is treated as a new request.
- Read data outputs hold their value until the next read by the same requester.

## Timing
- Reset values:
  - `c_rdata1`, `c_rdata2`, `d_rdata` = 0.
  - `c_rvalid`, `d_rvalid`, `init_done` = 0.
  - `rr_last` = 1, so the core wins the first tie.
  - `init_cnt` = 0.
- While `rst_n`=0, `rf_read_write` is forced to 0 and `c_gnt`/`d_gnt` to 0.
- The first grant is possible NUM_REGS cycles after reset deassertion (cycle 8 with defaults).
- Write latency: the register is updated at the rising edge that ends the grant cycle. A read granted in the next cycle returns the new value.
- Read latency: `rvalid` and data appear one cycle after `gnt`, as a pulse of exactly one cycle.
- Back-to-back grants to the same requester occur only when the other requester is idle.
- Worst-case wait under contention is one cycle.
- Reset asserted mid-operation: all registered outputs clear immediately and the FSM returns to INIT. The full clear sequence reruns, and a pending `rvalid` is lost.
- `init_cnt` is ADDR_W+1 bits wide, so terminal detection at NUM_REGS-1 has no wrap ambiguity.

## Structure
- Shared package `scmips_pkg` holds:
  - FSM state enum `rfa_state_t` {INIT, ARB}.
  - Constants `RF_READ`=0 and `RF_WRITE`=1 for the mode line.
  - `RF_ADDR_W`=3 and `RF_DATA_W`=8.
- One natural sub-module: `rr_arbiter2`, a two-way round-robin grant with `last` pointer state.

## Test plan
- Reset release, no requests:
  - `rf_read_write`=1 with `rf_write` stepping 0..7 over 8 cycles.
  - `init_done` rises in cycle 8.
  - Then a core read of r5 gives `c_rdata1`=0x00.
- Core writes r3=0xA5, then core reads r3/r0:
  - `c_gnt` in each request cycle.
  - `c_rvalid` one cycle after the read grant, with `c_rdata1`=0xA5 and `c_rdata2`=0x00.
- Core and debug requesting continuously from the first ARB cycle:
  - Grants alternate core, debug, core, debug.
  - Never two consecutive grants to the same side.
- Debug writes r7=0x3C while the core requests a read of r7 in the same cycle:
  - Core is granted first and reads the old value 0x00.
  - Debug writes next cycle.
  - A following core read returns 0x3C.
- Debug read of r2 after a core write of 0x11:
  - `d_rvalid` one cycle after `d_gnt` with `d_rdata`=0x11.
  - `c_rvalid` stays 0.
- `rst_n` pulsed low during a core read-grant cycle:
  - No `c_rvalid`; outputs go to 0 immediately.
  - INIT reruns for 8 cycles and a previously written r3 then reads 0x00.
